// File: rtl/cnn_out_buffer.sv
// ---------------------------------------------------------------------------
// cnn_out_buffer
//
// Purpose:
//   Output buffer between the last conv/pool stage and the serial result
//   interface. One CH-lane pixel word is accepted per cycle. Each lane goes
//   into its own DEPTH-deep column. When the frame closes, the buffer drains
//   it as a serial stream of DATA_W samples. The drain order is set by ORDER:
//     ORDER = 0 : channel-major (ch0 addr0..len-1, then ch1, ...)
//     ORDER = 1 : address-major (addr0 ch0..CH-1, then addr1, ...)
//
// Ports:
//   clk         rising-edge clock
//   global_rst  asynchronous reset, active low
//   in_valid    input word valid
//   in_ready    buffer can accept a word (high only while filling)
//   in_data     CH lanes; lane k is in_data[k*DATA_W +: DATA_W]
//   in_last     marks the final word of the frame
//   out_valid   out_data holds a sample
//   out_ready   downstream accepts the sample
//   out_data    drained sample
//   out_ch      channel index of out_data
//   out_addr    word address of out_data
//   out_last    final sample of the drain
//   frame_len   number of words in the last closed frame
//   busy        high while draining
//   done        one-cycle pulse after the last sample is accepted
//   overflow    sticky; set when a full buffer closed the frame without in_last
// ---------------------------------------------------------------------------
module cnn_out_buffer #(
  parameter int DATA_W = 8,
  parameter int CH     = 8,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11,
  parameter int CH_W   = 3,
  parameter int ORDER  = 0
) (
  input  logic                 clk,
  input  logic                 global_rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [CH_W-1:0]      out_ch,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 out_last,
  output logic [ADDR_W:0]      frame_len,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Storage: one column per channel.
  logic [DATA_W-1:0] r_mem [CH][DEPTH];

  // Write side
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_frame_len;
  logic              r_overflow;

  // Read walker
  logic [CH_W-1:0]   r_rd_ch;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_done;

  // Stage after the memory read
  logic              r_p_valid;
  logic [DATA_W-1:0] r_p_data;
  logic [CH_W-1:0]   r_p_ch;
  logic [ADDR_W-1:0] r_p_addr;
  logic              r_p_last;

  // Two-entry output queue
  logic [DATA_W-1:0] r_q_data [2];
  logic [CH_W-1:0]   r_q_ch   [2];
  logic [ADDR_W-1:0] r_q_addr [2];
  logic              r_q_last [2];
  logic              r_q_wptr;
  logic              r_q_rptr;
  logic [1:0]        r_q_cnt;

  logic              w_accept;
  logic              w_wr_full;
  logic              w_close;
  logic [ADDR_W:0]   w_len_m1;
  logic              w_rd_addr_end;
  logic              w_rd_ch_end;
  logic              w_rd_last;
  logic              w_pop;
  logic [2:0]        w_occ;
  logic              w_issue;
  logic              w_final_pop;

  assign in_ready  = (r_state == S_FILL);
  assign busy      = (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign frame_len = r_frame_len;
  assign overflow  = r_overflow;

  assign out_valid = (r_q_cnt != 2'd0);
  assign out_data  = r_q_data[r_q_rptr];
  assign out_ch    = r_q_ch[r_q_rptr];
  assign out_addr  = r_q_addr[r_q_rptr];
  assign out_last  = r_q_last[r_q_rptr];

  assign w_accept  = in_valid && in_ready;
  assign w_wr_full = (r_wr_ptr == ADDR_W'(DEPTH - 1));
  assign w_close   = w_accept && (in_last || w_wr_full);

  // The walker wraps at the captured frame length, never at DEPTH.
  assign w_len_m1      = r_frame_len - (ADDR_W + 1)'(1);
  assign w_rd_addr_end = ({1'b0, r_rd_addr} == w_len_m1);
  assign w_rd_ch_end   = (r_rd_ch == CH_W'(CH - 1));
  assign w_rd_last     = w_rd_addr_end && w_rd_ch_end;

  assign w_pop       = out_valid && out_ready;
  assign w_final_pop = w_pop && out_last;

  // A read may start only if its sample will find a free queue slot when
  // it lands two edges later. Occupancy is counted after this cycle's pop.
  // That count includes the sample already in flight. Later pops can only
  // free more space. With out_ready high this allows one read per cycle.
  assign w_occ   = 3'(r_q_cnt) + 3'(r_p_valid) - 3'(w_pop);
  assign w_issue = (r_state == S_DRAIN) && !r_rd_done && (w_occ <= 3'd1);

  // State register
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FILL:  if (w_close) w_next_state = S_DRAIN;
      S_DRAIN: if (w_final_pop) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_FILL;
      default: w_next_state = S_FILL;
    endcase
  end

  // Memory: all lanes are written together. One lane is read per cycle.
  // The read register has no reset because r_p_valid qualifies it.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < CH; k++) begin
        r_mem[k][r_wr_ptr] <= in_data[k*DATA_W +: DATA_W];
      end
    end
    if (w_issue) begin
      r_p_data <= r_mem[r_rd_ch][r_rd_addr];
    end
  end

  // Write pointer, frame length and sticky overflow flag
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      r_wr_ptr    <= '0;
      r_frame_len <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_close) begin
        r_frame_len <= {1'b0, r_wr_ptr} + (ADDR_W + 1)'(1);
        if (!in_last) begin
          r_overflow <= 1'b1;
        end
      end
      if (r_state == S_DONE) begin
        r_wr_ptr <= '0;
      end
    end
  end

  // Read walker. It is re-armed when a frame closes and stops after the last sample.
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      r_rd_ch   <= '0;
      r_rd_addr <= '0;
      r_rd_done <= 1'b0;
    end else if (w_close) begin
      r_rd_ch   <= '0;
      r_rd_addr <= '0;
      r_rd_done <= 1'b0;
    end else if (w_issue) begin
      if (w_rd_last) begin
        r_rd_done <= 1'b1;
      end else if (ORDER == 0) begin
        if (w_rd_addr_end) begin
          r_rd_addr <= '0;
          r_rd_ch   <= r_rd_ch + CH_W'(1);
        end else begin
          r_rd_addr <= r_rd_addr + ADDR_W'(1);
        end
      end else begin
        if (w_rd_ch_end) begin
          r_rd_ch   <= '0;
          r_rd_addr <= r_rd_addr + ADDR_W'(1);
        end else begin
          r_rd_ch <= r_rd_ch + CH_W'(1);
        end
      end
    end
  end

  // Tags for the sample being read. They stay aligned with the memory output.
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      r_p_valid <= 1'b0;
      r_p_ch    <= '0;
      r_p_addr  <= '0;
      r_p_last  <= 1'b0;
    end else begin
      r_p_valid <= w_issue;
      if (w_issue) begin
        r_p_ch   <= r_rd_ch;
        r_p_addr <= r_rd_addr;
        r_p_last <= w_rd_last;
      end
    end
  end

  // Output queue. It holds the sample on out_* and absorbs the in-flight
  // read when the consumer stalls.
  always_ff @(posedge clk or negedge global_rst) begin
    if (!global_rst) begin
      for (int e = 0; e < 2; e++) begin
        r_q_data[e] <= '0;
        r_q_ch[e]   <= '0;
        r_q_addr[e] <= '0;
        r_q_last[e] <= 1'b0;
      end
      r_q_wptr <= 1'b0;
      r_q_rptr <= 1'b0;
      r_q_cnt  <= 2'd0;
    end else begin
      if (r_p_valid) begin
        r_q_data[r_q_wptr] <= r_p_data;
        r_q_ch[r_q_wptr]   <= r_p_ch;
        r_q_addr[r_q_wptr] <= r_p_addr;
        r_q_last[r_q_wptr] <= r_p_last;
        r_q_wptr           <= ~r_q_wptr;
      end
      if (w_pop) begin
        r_q_rptr <= ~r_q_rptr;
      end
      r_q_cnt <= r_q_cnt + 2'(r_p_valid) - 2'(w_pop);
    end
  end

endmodule

// File: tb/tb_cnn_out_buffer.sv
// ---------------------------------------------------------------------------
// tb_cnn_out_buffer
//
// Two buffers share the same stimulus. One drains channel-major and the
// other drains address-major. When a frame closes, the bench builds the
// drain order for each buffer from the captured words and queues it.
// Per-instance monitors pop the queues whenever a sample is accepted.
// ---------------------------------------------------------------------------
module tb_cnn_out_buffer;

  localparam int DW  = 8;
  localparam int CHN = 8;
  localparam int DEP = 16;
  localparam int AW  = 4;
  localparam int CW  = 3;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic [AW-1:0] a;
    logic          l;
  } sample_t;

  logic clk = 1'b0;
  logic global_rst;
  logic in_valid;
  logic [CHN*DW-1:0] in_data;
  logic in_last;
  logic out_ready;

  logic rdy0, vld0, lst0, bsy0, dn0, ovf0;
  logic [DW-1:0] dat0;
  logic [CW-1:0] ch0;
  logic [AW-1:0] adr0;
  logic [AW:0]   len0;
  logic rdy1, vld1, lst1, bsy1, dn1, ovf1;
  logic [DW-1:0] dat1;
  logic [CW-1:0] ch1;
  logic [AW-1:0] adr1;
  logic [AW:0]   len1;

  sample_t q0[$];
  sample_t q1[$];
  logic [CHN*DW-1:0] frm[$];

  int total = 0;
  int bad = 0;
  int doneCnt[2];
  int popCnt[2];
  bit prevStall[2];
  sample_t prevS[2];
  bit randReady = 1'b0;

  always #5 clk = ~clk;

  cnn_out_buffer #(.DATA_W(DW), .CH(CHN), .DEPTH(DEP), .ADDR_W(AW), .CH_W(CW), .ORDER(0)) u0 (
    .clk(clk), .global_rst(global_rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_last(in_last), .out_valid(vld0), .out_ready(out_ready),
    .out_data(dat0), .out_ch(ch0), .out_addr(adr0), .out_last(lst0),
    .frame_len(len0), .busy(bsy0), .done(dn0), .overflow(ovf0));

  cnn_out_buffer #(.DATA_W(DW), .CH(CHN), .DEPTH(DEP), .ADDR_W(AW), .CH_W(CW), .ORDER(1)) u1 (
    .clk(clk), .global_rst(global_rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_last(in_last), .out_valid(vld1), .out_ready(out_ready),
    .out_data(dat1), .out_ch(ch1), .out_addr(adr1), .out_last(lst1),
    .frame_len(len1), .busy(bsy1), .done(dn1), .overflow(ovf1));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Builds the expected drain for both orders from the captured frame.
  task automatic pushExpected();
    int n;
    sample_t s;
    n = frm.size();
    for (int c = 0; c < CHN; c++) begin
      for (int a = 0; a < n; a++) begin
        s.d = frm[a][c*DW +: DW];
        s.c = CW'(c);
        s.a = AW'(a);
        s.l = (c == CHN - 1) && (a == n - 1);
        q0.push_back(s);
      end
    end
    for (int a = 0; a < n; a++) begin
      for (int c = 0; c < CHN; c++) begin
        s.d = frm[a][c*DW +: DW];
        s.c = CW'(c);
        s.a = AW'(a);
        s.l = (c == CHN - 1) && (a == n - 1);
        q1.push_back(s);
      end
    end
  endtask

  task automatic monitorStep(input int i, input logic v, input logic r, input sample_t act, input logic dn);
    sample_t e;
    int qs;
    if (global_rst !== 1'b1) begin
      prevStall[i] = 1'b0;
      return;
    end
    if (prevStall[i]) begin
      checkOutput(i == 0 ? "stable0" : "stable1", {15'd0, v, act}, {15'd0, 1'b1, prevS[i]});
    end
    if (v && r) begin
      qs = (i == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedSample%0d: got %0h expected none", i, act);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        checkOutput(i == 0 ? "sample0" : "sample1", act, e);
      end
      popCnt[i]++;
    end
    prevStall[i] = v && !r;
    prevS[i] = act;
    if (dn) begin
      doneCnt[i]++;
      checkOutput(i == 0 ? "doneNoValid0" : "doneNoValid1", v, 0);
    end
  endtask

  always @(negedge clk) monitorStep(0, vld0, out_ready, {dat0, ch0, adr0, lst0}, dn0);
  always @(negedge clk) monitorStep(1, vld1, out_ready, {dat1, ch1, adr1, lst1}, dn1);

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Sends n words. Pattern data puts 16*w+k in lane k. The frame closes on
  // in_last or when the buffer is full.
  task automatic applyStimulus(input int n, input bit withLast, input bit randData);
    logic [CHN*DW-1:0] word;
    frm.delete();
    for (int w = 0; w < n; w++) begin
      @(posedge clk);
      #1;
      if (randData) begin
        word = {$urandom, $urandom};
      end else begin
        for (int k = 0; k < CHN; k++) word[k*DW +: DW] = DW'(16 * w + k);
      end
      in_valid = 1'b1;
      in_data  = word;
      in_last  = withLast && (w == n - 1);
      frm.push_back(word);
      checkOutput("inReady0", rdy0, 1);
      checkOutput("inReady1", rdy1, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    pushExpected();
    checkOutput("busyAfterClose0", bsy0, 1);
    checkOutput("busyAfterClose1", bsy1, 1);
  endtask

  task automatic checkLatency();
    checkOutput("latT0", {vld1, vld0}, 2'b00);
    @(posedge clk);
    #1;
    checkOutput("latT1", {vld1, vld0}, 2'b00);
    @(posedge clk);
    #1;
    checkOutput("latT2", {vld1, vld0}, 2'b11);
  endtask

  task automatic waitDone(input int expLen, input bit expOvf);
    int d0;
    int d1;
    int cyc;
    d0 = doneCnt[0];
    d1 = doneCnt[1];
    cyc = 0;
    while ((doneCnt[0] == d0 || doneCnt[1] == d1) && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("doneSeen", (cyc < 3000) ? 1 : 0, 1);
    checkOutput("doneOnce0", doneCnt[0] - d0, 1);
    checkOutput("doneOnce1", doneCnt[1] - d1, 1);
    checkOutput("q0Empty", q0.size(), 0);
    checkOutput("q1Empty", q1.size(), 0);
    checkOutput("inReadyAfterDone", {rdy1, rdy0}, 2'b11);
    checkOutput("donePulse", {dn1, dn0}, 2'b00);
    checkOutput("frameLen0", len0, expLen);
    checkOutput("frameLen1", len1, expLen);
    checkOutput("overflow0", ovf0, expOvf);
    checkOutput("overflow1", ovf1, expOvf);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_inReady"}, {rdy1, rdy0}, 2'b11);
    checkOutput({tag, "_outValid"}, {vld1, vld0}, 2'b00);
    checkOutput({tag, "_busy"}, {bsy1, bsy0}, 2'b00);
    checkOutput({tag, "_done"}, {dn1, dn0}, 2'b00);
    checkOutput({tag, "_overflow"}, {ovf1, ovf0}, 2'b00);
    checkOutput({tag, "_outData"}, {dat1, dat0}, 0);
    checkOutput({tag, "_outCh"}, {ch1, ch0}, 0);
    checkOutput({tag, "_outAddr"}, {adr1, adr0}, 0);
    checkOutput({tag, "_outLast"}, {lst1, lst0}, 2'b00);
    checkOutput({tag, "_frameLen"}, {len1, len0}, 0);
  endtask

  initial begin
    int p0;
    int cyc;
    int d0;
    int n;
    global_rst = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    global_rst = 1'b1;

    // 4-word pattern frame with out_ready held high
    applyStimulus(4, 1'b1, 1'b0);
    checkLatency();
    waitDone(4, 1'b0);

    // Same frame with random backpressure
    randReady = 1'b1;
    applyStimulus(4, 1'b1, 1'b0);
    checkLatency();
    waitDone(4, 1'b0);

    // Full buffer without in_last
    applyStimulus(DEP, 1'b0, 1'b0);
    checkOutput("ovfSet", {ovf1, ovf0}, 2'b11);
    checkOutput("ovfLen", len0, DEP);
    checkOutput("ovfInReady", {rdy1, rdy0}, 2'b00);
    waitDone(DEP, 1'b1);
    applyStimulus(4, 1'b1, 1'b1);
    waitDone(4, 1'b1);

    // Reset in the middle of a drain
    applyStimulus(8, 1'b1, 1'b1);
    p0 = popCnt[0];
    cyc = 0;
    while (popCnt[0] < p0 + 5 && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("fivePopped", (popCnt[0] >= p0 + 5) ? 1 : 0, 1);
    global_rst = 1'b0;
    #1;
    checkOutput("midRstValid", {vld1, vld0}, 2'b00);
    checkOutput("midRstBusy", {bsy1, bsy0}, 2'b00);
    checkOutput("midRstInReady", {rdy1, rdy0}, 2'b11);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    global_rst = 1'b1;
    applyStimulus(2, 1'b1, 1'b0);
    checkLatency();
    waitDone(2, 1'b0);

    // Single-word frame while in_valid stays high during the drain
    applyStimulus(1, 1'b1, 1'b1);
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom};
    d0 = doneCnt[0];
    cyc = 0;
    while (doneCnt[0] == d0 && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (doneCnt[0] == d0) begin
        checkOutput("drainInReady", {rdy1, rdy0}, 2'b00);
      end
    end
    in_valid = 1'b0;
    checkOutput("singleDone", doneCnt[0] - d0, 1);
    checkOutput("singleQ0", q0.size(), 0);
    checkOutput("singleQ1", q1.size(), 0);
    applyStimulus(3, 1'b1, 1'b0);
    waitDone(3, 1'b0);

    // Random frames
    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(1, DEP);
      applyStimulus(n, 1'b1, 1'b1);
      waitDone(n, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
